// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// Timed phase sequencer for a two-road intersection (main road, side road,
// pedestrian crossing). The main road rests in green; the side road and the
// pedestrian crossing are served on request. An all-red clearance always
// separates the two roads. A flash (fault) mode overrides normal sequencing.
//
// Lamp heads are one-hot: RED=3'b001, GREEN=3'b010, YELLOW=3'b100, and
// 3'b000 is dark. Dark only appears in flash mode.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (wins over flash and requests)
//   side_req    side-road vehicle sensor, level
//   ped_req     pedestrian button; any high cycle is latched
//   flash       fault/flash mode request, level
//   main_light  main-road lamp (one-hot)
//   side_light  side-road lamp (one-hot)
//   walk        pedestrian walk lamp
//   phase       current state code: MG=0 MY=1 AR1=2 SG=3 SY=4 AR2=5 WALK=6 FLASH=7
//
// All outputs are a pure decode of the registered state, so they change on
// the same edge as the state.
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl #(
  parameter int CW         = 4,
  parameter int MAIN_MIN   = 8,
  parameter int SIDE_GREEN = 5,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1,
  parameter int WALK_T     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_MG    = 3'd0,
    ST_MY    = 3'd1,
    ST_AR1   = 3'd2,
    ST_SG    = 3'd3,
    ST_SY    = 3'd4,
    ST_AR2   = 3'd5,
    ST_WALK  = 3'd6,
    ST_FLASH = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_DARK   = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b100;

  // A state with duration d has expired when the timer reads d-1, so the
  // state is visible for exactly d cycles.
  localparam logic [CW-1:0] TIMER_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] MAIN_LAST   = CW'(MAIN_MIN - 1);
  localparam logic [CW-1:0] SIDE_LAST   = CW'(SIDE_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_T - 1);

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] timer_reg;
  logic          ped_pending_reg;
  logic          blink_reg;
  logic          walk_entry;

  // Next-state selection; flash is checked before any per-state rule.
  always_comb begin
    state_next = state_reg;
    if (flash) begin
      state_next = ST_FLASH;
    end else begin
      case (state_reg)
        ST_MG: begin
          // The timer saturates, so >= keeps the minimum-green test valid
          // however long the main road has rested.
          if (timer_reg >= MAIN_LAST && (side_req || ped_pending_reg))
            state_next = ST_MY;
        end
        ST_MY: begin
          if (timer_reg == YELLOW_LAST) state_next = ST_AR1;
        end
        ST_AR1: begin
          if (timer_reg == ALLRED_LAST)
            state_next = ped_pending_reg ? ST_WALK : ST_SG;
        end
        ST_WALK: begin
          if (timer_reg == WALK_LAST)
            state_next = side_req ? ST_SG : ST_AR2;
        end
        ST_SG: begin
          if (timer_reg == SIDE_LAST) state_next = ST_SY;
        end
        ST_SY: begin
          if (timer_reg == YELLOW_LAST) state_next = ST_AR2;
        end
        ST_AR2: begin
          if (timer_reg == ALLRED_LAST) state_next = ST_MG;
        end
        ST_FLASH: begin
          state_next = ST_AR2;
        end
        default: begin
          state_next = ST_AR2;
        end
      endcase
    end
  end

  assign walk_entry = (state_next == ST_WALK) && (state_reg != ST_WALK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_AR2;
      timer_reg       <= '0;
      ped_pending_reg <= 1'b0;
      blink_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg)
        timer_reg <= '0;
      else if (timer_reg != TIMER_MAX)
        timer_reg <= timer_reg + CW'(1);

      // A press on the walk-entry edge wins over the clear, so that press
      // is served on a later cycle rather than lost.
      if (ped_req)
        ped_pending_reg <= 1'b1;
      else if (walk_entry)
        ped_pending_reg <= 1'b0;

      // Blink only runs while remaining in FLASH; it is 0 on entry and exit.
      if (state_reg == ST_FLASH && state_next == ST_FLASH)
        blink_reg <= ~blink_reg;
      else
        blink_reg <= 1'b0;
    end
  end

  // Moore output decode.
  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_reg)
      ST_MG: main_light = LAMP_GREEN;
      ST_MY: main_light = LAMP_YELLOW;
      ST_SG: side_light = LAMP_GREEN;
      ST_SY: side_light = LAMP_YELLOW;
      ST_WALK: walk = 1'b1;
      ST_FLASH: begin
        main_light = blink_reg ? LAMP_DARK : LAMP_YELLOW;
        side_light = blink_reg ? LAMP_DARK : LAMP_RED;
      end
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase
  end

  assign phase = state_reg;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//
// Self-checking bench for traffic_intersection_ctrl. A behavioural model
// (phase number, cycles spent in the phase, pending walk request, blink)
// runs alongside the DUT; one compare process checks all outputs on every
// falling edge. Directed scenarios pin the model with literal expectations,
// then a randomized run exercises the rest.
// -----------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

  localparam int MAIN_MIN   = 8;
  localparam int SIDE_GREEN = 5;
  localparam int YELLOW_T   = 2;
  localparam int ALLRED_T   = 1;
  localparam int WALK_T     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;

  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;
  int cycle = 0;

  traffic_intersection_ctrl #(
    .CW(4), .MAIN_MIN(MAIN_MIN), .SIDE_GREEN(SIDE_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst(rst), .side_req(side_req), .ped_req(ped_req),
    .flash(flash), .main_light(main_light), .side_light(side_light),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phases: 0 MG, 1 MY, 2 AR1, 3 SG, 4 SY, 5 AR2, 6 WALK, 7 FLASH.
  int m_phase = 5;
  int m_spent = 0;      // cycles already completed in the current phase
  bit m_ped = 1'b0;
  bit m_blink = 1'b0;

  function automatic int dur_of(input int p);
    case (p)
      0: dur_of = MAIN_MIN;
      1: dur_of = YELLOW_T;
      2: dur_of = ALLRED_T;
      3: dur_of = SIDE_GREEN;
      4: dur_of = YELLOW_T;
      5: dur_of = ALLRED_T;
      6: dur_of = WALK_T;
      default: dur_of = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit done;
    cycle++;
    if (rst) begin
      m_phase = 5; m_spent = 0; m_ped = 1'b0; m_blink = 1'b0;
    end else begin
      // The cycle ending at this edge counts toward the phase duration.
      done = (m_spent + 1) >= dur_of(m_phase);
      nxt = m_phase;
      if (flash) nxt = 7;
      else case (m_phase)
        0: if (done && (side_req || m_ped)) nxt = 1;
        1: if (done) nxt = 2;
        2: if (done) nxt = m_ped ? 6 : 3;
        3: if (done) nxt = 4;
        4: if (done) nxt = 5;
        5: if (done) nxt = 0;
        6: if (done) nxt = side_req ? 3 : 5;
        default: nxt = 5;
      endcase
      if (nxt == 6 && m_phase != 6) m_ped = 1'b0;
      if (ped_req) m_ped = 1'b1;
      m_blink = (nxt == 7 && m_phase == 7) ? !m_blink : 1'b0;
      m_spent = (nxt == m_phase) ? m_spent + 1 : 0;
      m_phase = nxt;
    end
  end

  function automatic logic [2:0] model_main(input int p, input bit b);
    case (p)
      0: model_main = 3'b010;
      1: model_main = 3'b100;
      7: model_main = b ? 3'b000 : 3'b100;
      default: model_main = 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] model_side(input int p, input bit b);
    case (p)
      3: model_side = 3'b010;
      4: model_side = 3'b100;
      7: model_side = b ? 3'b000 : 3'b001;
      default: model_side = 3'b001;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [2:0] em, es;
    logic ew;
    if (chk) begin
      em = model_main(m_phase, m_blink);
      es = model_side(m_phase, m_blink);
      ew = (m_phase == 6);
      vectors++;
      if (main_light !== em || side_light !== es || walk !== ew ||
          phase !== 3'(m_phase)) begin
        miscompares++;
        $display("FAIL model cyc%0d: dut main=%b side=%b walk=%b phase=%0d, expected main=%b side=%b walk=%b phase=%0d",
                 cycle, main_light, side_light, walk, phase, em, es, ew, m_phase);
      end
      vectors++;
      if (phase !== 3'd7 && main_light !== 3'b001 && side_light !== 3'b001) begin
        miscompares++;
        $display("FAIL safety cyc%0d: main=%b side=%b phase=%0d, required one road RED",
                 cycle, main_light, side_light, phase);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input int ph, input logic [2:0] em,
                           input logic [2:0] es, input logic ew);
    vectors++;
    if (phase !== 3'(ph) || main_light !== em || side_light !== es || walk !== ew) begin
      miscompares++;
      $display("FAIL %s: got phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
               name, phase, main_light, side_light, walk, ph, em, es, ew);
    end
  endtask

  int exp_q[$];

  task automatic add_run(input int p, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(p);
  endtask

  // Checks the phase on consecutive falling edges, starting at the current one.
  task automatic run_seq(input string name);
    int k = 0;
    while (exp_q.size() > 0) begin
      int p = exp_q.pop_front();
      vectors++;
      if (phase !== 3'(p)) begin
        miscompares++;
        $display("FAIL %s step%0d: got phase=%0d, required %0d", name, k, phase, p);
      end
      k++;
      tick();
    end
  endtask

  // Leaves the DUT at the first falling edge of a fresh main-green.
  task automatic restart();
    side_req = 1'b0; ped_req = 1'b0; flash = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset, then rest in main green
    tick(); tick();
    chk = 1'b1;
    rst = 1'b0;
    check_lit("s1_ar2", 5, 3'b001, 3'b001, 1'b0);
    tick();
    check_lit("s1_mg", 0, 3'b010, 3'b001, 1'b0);
    repeat (50) tick();
    check_lit("s1_hold", 0, 3'b010, 3'b001, 1'b0);
    $display("scenario 1: idle main green checked");

    // 2. side request from MG entry
    restart();
    side_req = 1'b1;
    add_run(0, 8); add_run(1, 2); add_run(2, 1); add_run(3, 5);
    add_run(4, 2); add_run(5, 1); add_run(0, 1);
    run_seq("s2_side");
    $display("scenario 2: side cycle checked");

    // 3. single pedestrian press at MG cycle 3
    restart();
    tick(); tick();
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    add_run(0, 5); add_run(1, 2); add_run(2, 1);
    run_seq("s3_pre");
    check_lit("s3_walk", 6, 3'b001, 3'b001, 1'b1);
    add_run(6, 4); add_run(5, 1); add_run(0, 1);
    run_seq("s3_post");
    repeat (20) tick();
    check_lit("s3_no_repeat", 0, 3'b010, 3'b001, 1'b0);
    $display("scenario 3: pedestrian walk checked");

    // 4. pedestrian and side together
    restart();
    side_req = 1'b1; ped_req = 1'b1; tick(); ped_req = 1'b0;
    add_run(0, 7); add_run(1, 2); add_run(2, 1); add_run(6, 4);
    add_run(3, 5); add_run(4, 2); add_run(5, 1); add_run(0, 1);
    run_seq("s4_both");
    $display("scenario 4: walk then side checked");

    // 5. flash during side green
    restart();
    side_req = 1'b1;
    repeat (11) tick();
    side_req = 1'b0;
    check_lit("s5_sg", 3, 3'b001, 3'b010, 1'b0);
    flash = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) check_lit("s5_flash_on", 7, 3'b100, 3'b001, 1'b0);
      else            check_lit("s5_flash_off", 7, 3'b000, 3'b000, 1'b0);
    end
    flash = 1'b0;
    tick();
    check_lit("s5_ar2", 5, 3'b001, 3'b001, 1'b0);
    tick();
    check_lit("s5_mg", 0, 3'b010, 3'b001, 1'b0);
    $display("scenario 5: flash mode checked");

    // 6. reset mid-SY with a pending pedestrian request
    restart();
    side_req = 1'b1;
    repeat (11) tick();
    side_req = 1'b0;
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    repeat (4) tick();
    check_lit("s6_sy", 4, 3'b001, 3'b100, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_lit("s6_reset", 5, 3'b001, 3'b001, 1'b0);
    repeat (25) tick();
    check_lit("s6_ped_cleared", 0, 3'b010, 3'b001, 1'b0);
    $display("scenario 6: reset mid-sequence checked");

    // 7. randomized traffic
    for (int i = 0; i < 4000; i++) begin
      side_req = ($urandom_range(0, 99) < 30);
      ped_req  = ($urandom_range(0, 99) < 4);
      if (flash) flash = ($urandom_range(0, 99) < 85);
      else       flash = ($urandom_range(0, 999) < 8);
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0; flash = 1'b0; side_req = 1'b0; ped_req = 1'b0;
    tick(); tick();
    $display("scenario 7: randomized traffic checked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
